// File: rtl/alzette_seq_ise_if.sv
// Request/response bundle for the iterative Alzette ISE unit.
// Handshake: a request transfers on a rising edge when ise_val, ise_sel and ise_rdy are all high;
// a response transfers on a rising edge when ise_oval and ise_ordy are both high, and the unit
// holds ise_out/ise_oval steady while ise_oval=1 and ise_ordy=0.
interface alzette_seq_ise_if;
  logic        ise_val;
  logic        ise_rdy;
  logic [4:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [63:0] ise_in1;
  logic [63:0] ise_in2;
  logic        ise_flush;
  logic        ise_sel;
  logic        ise_oval;
  logic        ise_ordy;
  logic [63:0] ise_out;
  logic        ise_busy;
  logic [1:0]  dbg_state;

  modport master (
    output ise_val, ise_fn, ise_imm, ise_in1, ise_in2, ise_flush, ise_ordy,
    input  ise_rdy, ise_sel, ise_oval, ise_out, ise_busy, dbg_state
  );

  modport slave (
    input  ise_val, ise_fn, ise_imm, ise_in1, ise_in2, ise_flush, ise_ordy,
    output ise_rdy, ise_sel, ise_oval, ise_out, ise_busy, dbg_state
  );
endinterface

// File: rtl/alzette_seq_ise.sv
// Iterative Alzette ARX-box (4 steps, encrypt or decrypt) for the rv64 custom-ALU slot.
// STEPS_PER_CYC chained steps are evaluated per RUN cycle; the result is registered on the last one.
module alzette_seq_ise #(
  parameter int         STEPS_PER_CYC = 1,
  parameter bit         EN_DEC        = 1'b1,
  parameter logic [6:0] FUNCT_ENC     = 7'h70,
  parameter logic [6:0] FUNCT_DEC     = 7'h71
) (
  input logic              ise_clk,
  input logic              ise_rst,
  alzette_seq_ise_if.slave bus
);
  localparam int         RUN_CYCLES = 4 / STEPS_PER_CYC;
  localparam logic [1:0] LAST_CNT   = 2'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] x_q;
  logic [31:0] y_q;
  logic [31:0] c_q;
  logic        dec_q;
  logic        oval_q;
  logic [63:0] out_q;

  logic        hit_enc;
  logic        hit_dec;
  logic        accept;
  logic [1:0]  base;
  logic [31:0] x_n;
  logic [31:0] y_n;
  logic        unused_bits;

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] t;
    t = {v, v} >> r;
    return t[31:0];
  endfunction

  // One ARX step; returns {y, x}. Decrypt is the exact inverse of the encrypt step.
  function automatic logic [63:0] arx_step(input logic [31:0] x_i, input logic [31:0] y_i,
                                           input logic [31:0] c_i, input logic [1:0] idx,
                                           input logic dec);
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] x;
    logic [31:0] y;
    case (idx)
      2'd0:    begin r1 = 5'd31; r2 = 5'd24; end
      2'd1:    begin r1 = 5'd17; r2 = 5'd17; end
      2'd2:    begin r1 = 5'd0;  r2 = 5'd31; end
      default: begin r1 = 5'd24; r2 = 5'd16; end
    endcase
    x = x_i;
    y = y_i;
    if (!dec) begin
      x = x + ror32(y, r1);
      y = y ^ ror32(x, r2);
      x = x ^ c_i;
    end else begin
      x = x ^ c_i;
      y = y ^ ror32(x, r2);
      x = x - ror32(y, r1);
    end
    return {y, x};
  endfunction

  assign hit_enc = (bus.ise_fn[1:0] == 2'b10) && (bus.ise_imm == FUNCT_ENC);
  assign hit_dec = EN_DEC && (bus.ise_fn[1:0] == 2'b10) && (bus.ise_imm == FUNCT_DEC);

  assign bus.ise_sel   = bus.ise_val & (hit_enc | hit_dec);
  assign bus.ise_rdy   = (state == S_IDLE) & ~ise_rst;
  assign bus.ise_busy  = (state != S_IDLE);
  assign bus.ise_oval  = oval_q;
  assign bus.ise_out   = out_q;
  assign bus.dbg_state = state;

  assign accept = bus.ise_sel & bus.ise_rdy;

  // Only rs2[31:0] and fn[1:0] carry meaning for this unit.
  assign unused_bits = ^{bus.ise_in2[63:32], bus.ise_fn[4:2]};

  // Decrypt walks the step tables backwards, so its index is mirrored.
  always_comb begin
    logic [63:0] yx;
    logic [1:0]  idx;
    base = 2'(cnt * STEPS_PER_CYC);
    yx   = {y_q, x_q};
    idx  = 2'd0;
    for (int k = 0; k < STEPS_PER_CYC; k++) begin
      idx = base + 2'(k);
      if (dec_q) idx = 2'd3 - idx;
      yx = arx_step(yx[31:0], yx[63:32], c_q, idx, dec_q);
    end
    x_n = yx[31:0];
    y_n = yx[63:32];
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      x_q    <= 32'd0;
      y_q    <= 32'd0;
      c_q    <= 32'd0;
      dec_q  <= 1'b0;
      oval_q <= 1'b0;
      out_q  <= 64'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // A flush arriving with the request cancels it.
          if (accept && !bus.ise_flush) begin
            x_q   <= bus.ise_in1[31:0];
            y_q   <= bus.ise_in1[63:32];
            c_q   <= bus.ise_in2[31:0];
            dec_q <= hit_dec;
            cnt   <= 2'd0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.ise_flush) begin
            state <= S_IDLE;
          end else begin
            x_q <= x_n;
            y_q <= y_n;
            cnt <= cnt + 2'd1;
            if (cnt == LAST_CNT) begin
              out_q  <= {y_n, x_n};
              oval_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.ise_flush || bus.ise_ordy) begin
            oval_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          oval_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alzette_seq_ise.sv
// Bench for alzette_seq_ise: four instances (1/2/4 steps per cycle, and decrypt disabled) share
// one stimulus stream; per-lane monitors pop expected results from queues as responses appear.
module tb_alzette_seq_ise;
  localparam logic [4:0]  FN_OK   = 5'b00010;
  localparam logic [6:0]  IMM_ENC = 7'h70;
  localparam logic [6:0]  IMM_DEC = 7'h71;
  localparam logic [63:0] V_ONE   = 64'h00000000_00000001;
  localparam logic [63:0] K_ONE   = 64'h424381C6_02044342;
  localparam logic [63:0] V_A     = 64'h01234567_89ABCDEF;
  localparam logic [63:0] C_A     = 64'h00000000_B7E15162;
  localparam logic [63:0] V_B     = 64'hFEDCBA98_76543210;
  localparam logic [63:0] C_B     = 64'hDEADBEEF_13198A2E;

  // ---------------- clock / reset / shared stimulus ----------------
  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        val;
  logic        flush;
  logic [4:0]  fn;
  logic [6:0]  imm;
  logic [63:0] in1;
  logic [63:0] in2;
  logic [3:0]  en;
  logic [3:0]  ordy;

  logic [3:0]  rdy_w;
  logic [3:0]  sel_w;
  logic [3:0]  oval_w;
  logic [3:0]  busy_w;
  logic [63:0] out_w [4];
  logic [1:0]  dbg_w [4];

  logic [63:0] exp_q [4][$];
  int          cyc_q [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    if (n == 0) return v;
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic int rot1(input int i);
    case (i)
      0: return 31;
      1: return 17;
      2: return 0;
      default: return 24;
    endcase
  endfunction

  function automatic int rot2(input int i);
    case (i)
      0: return 24;
      1: return 17;
      2: return 31;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] alz_model(input logic [63:0] xy, input logic [31:0] c, input bit dec);
    logic [31:0] x;
    logic [31:0] y;
    x = xy[31:0];
    y = xy[63:32];
    if (!dec) begin
      for (int i = 0; i < 4; i++) begin
        x = x + rotr(y, rot1(i));
        y = y ^ rotr(x, rot2(i));
        x = x ^ c;
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        x = x ^ c;
        y = y ^ rotr(x, rot2(i));
        x = x - rotr(y, rot1(i));
      end
    end
    return {y, x};
  endfunction

  function automatic int lane_lat(input int l);
    return (l == 1) ? 2 : ((l == 2) ? 1 : 4);
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int l = 0; l < 4; l++) n += exp_q[l].size();
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // ---------------- DUT lanes and monitors ----------------
  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int SPC     = (g == 1) ? 2 : ((g == 2) ? 4 : 1);
    localparam bit HAS_DEC = (g != 3);

    alzette_seq_ise_if lane_if ();

    assign lane_if.ise_val   = val & en[g];
    assign lane_if.ise_fn    = fn;
    assign lane_if.ise_imm   = imm;
    assign lane_if.ise_in1   = in1;
    assign lane_if.ise_in2   = in2;
    assign lane_if.ise_flush = flush & en[g];
    assign lane_if.ise_ordy  = ordy[g];
    assign rdy_w[g]  = lane_if.ise_rdy;
    assign sel_w[g]  = lane_if.ise_sel;
    assign oval_w[g] = lane_if.ise_oval;
    assign busy_w[g] = lane_if.ise_busy;
    assign out_w[g]  = lane_if.ise_out;
    assign dbg_w[g]  = lane_if.dbg_state;

    alzette_seq_ise #(
      .STEPS_PER_CYC (SPC),
      .EN_DEC        (HAS_DEC)
    ) u_dut (
      .ise_clk (clk),
      .ise_rst (rst),
      .bus     (lane_if)
    );

    initial begin : mon
      logic        prev_ov;
      logic [63:0] last_out;
      prev_ov  = 1'b0;
      last_out = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_ov = 1'b0;
        end else begin
          if (oval_w[g]) begin
            if (!prev_ov) begin
              if (exp_q[g].size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_oval lane%0d: got out=%h expected no response", g, out_w[g]);
              end else begin
                check($sformatf("out_lane%0d", g), out_w[g], exp_q[g][0]);
                check($sformatf("latency_lane%0d", g), 64'(cyc), 64'(cyc_q[g][0]));
              end
            end else begin
              check($sformatf("hold_out_lane%0d", g), out_w[g], last_out);
            end
            check_bit($sformatf("rdy_in_done_lane%0d", g), rdy_w[g], 1'b0);
            if (ordy[g] && exp_q[g].size() != 0) begin
              void'(exp_q[g].pop_front());
              void'(cyc_q[g].pop_front());
            end
          end
          prev_ov  = oval_w[g];
          last_out = out_w[g];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] m, input logic [4:0] f, input logic [6:0] im,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] e,
                       input logic [3:0] exp_sel);
    int guard;
    guard = 0;
    while (((rdy_w & m) != m) && guard < 50) begin
      tick();
      guard++;
    end
    if ((rdy_w & m) != m) begin
      n_checks++;
      n_errors++;
      $display("FAIL rdy_timeout: got rdy=%b expected %b", rdy_w, m);
    end
    fn = f; imm = im; in1 = a; in2 = b; en = m; val = 1'b1;
    #1;
    check("sel", {60'd0, sel_w}, {60'd0, exp_sel});
    for (int l = 0; l < 4; l++) begin
      if (exp_sel[l]) begin
        exp_q[l].push_back(e);
        cyc_q[l].push_back(cyc + 1 + lane_lat(l));
      end
    end
    tick();
    val = 1'b0;
    en  = 4'd0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((busy_w != 4'd0 || pending() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_pending", 64'(pending()), 64'd0);
    check("drain_busy", {60'd0, busy_w}, 64'd0);
  endtask

  task automatic wait_oval(input int l);
    int guard;
    guard = 0;
    while (!oval_w[l] && guard < 20) begin
      tick();
      guard++;
    end
    check_bit("oval_seen", oval_w[l], 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] ct_a;
    logic [63:0] ct_b;
    ct_a = alz_model(V_A, C_A[31:0], 1'b0);
    ct_b = alz_model(V_B, C_B[31:0], 1'b0);

    // Reset held while a legal encrypt request is offered.
    rst = 1'b1; val = 1'b1; flush = 1'b0; fn = FN_OK; imm = IMM_ENC;
    in1 = V_ONE; in2 = 64'd0; en = 4'hF; ordy = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      check_bit("rst_oval", oval_w[l], 1'b0);
      check("rst_out", out_w[l], 64'd0);
      check_bit("rst_rdy", rdy_w[l], 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; val = 1'b0; en = 4'd0;
    #1;
    for (int l = 0; l < 4; l++) begin
      check_bit("post_rst_rdy", rdy_w[l], 1'b1);
      check_bit("post_rst_busy", busy_w[l], 1'b0);
    end

    // Known-answer encrypt on every lane.
    issue(4'hF, FN_OK, IMM_ENC, V_ONE, 64'd0, K_ONE, 4'hF);
    drain();

    // Round trips; the decrypt-less lane only takes the encrypt half.
    issue(4'hF, FN_OK, IMM_ENC, V_A, C_A, ct_a, 4'hF);
    drain();
    issue(4'b0111, FN_OK, IMM_DEC, ct_a, C_A, V_A, 4'b0111);
    drain();
    issue(4'hF, FN_OK, IMM_ENC, V_B, C_B, ct_b, 4'hF);
    drain();
    issue(4'b0111, FN_OK, IMM_DEC, ct_b, C_B, V_B, 4'b0111);
    drain();

    // Decode: wrong opcode bits or funct are ignored; only fn[1:0] matters.
    issue(4'hF, 5'b00011, IMM_ENC, V_A, C_A, 64'd0, 4'd0);
    check("dec_fn_busy", {60'd0, busy_w}, 64'd0);
    issue(4'hF, FN_OK, 7'h72, V_A, C_A, 64'd0, 4'd0);
    check("dec_imm_busy", {60'd0, busy_w}, 64'd0);
    for (int l = 0; l < 4; l++) check("dec_state_idle", {62'd0, dbg_w[l]}, 64'd0);
    issue(4'hF, 5'b11110, IMM_ENC, V_ONE, 64'd0, K_ONE, 4'hF);
    drain();
    issue(4'hF, FN_OK, IMM_DEC, V_A, C_A, alz_model(V_A, C_A[31:0], 1'b1), 4'b0111);
    check("dec_disabled_busy", {60'd0, busy_w}, {60'd0, 4'b0111});
    drain();

    // Backpressure on lane 0 with a second request waiting.
    ordy = 4'b1110;
    issue(4'b0001, FN_OK, IMM_ENC, V_ONE, 64'd0, K_ONE, 4'b0001);
    wait_oval(0);
    fn = FN_OK; imm = IMM_ENC; in1 = V_A; in2 = C_A; en = 4'b0001; val = 1'b1;
    repeat (5) begin
      tick();
      check_bit("bp_busy", busy_w[0], 1'b1);
      check_bit("bp_oval", oval_w[0], 1'b1);
    end
    ordy = 4'hF;
    exp_q[0].push_back(ct_a);
    cyc_q[0].push_back(cyc + 2 + 4);
    tick();
    check_bit("bp_idle_rdy", rdy_w[0], 1'b1);
    check_bit("bp_idle_busy", busy_w[0], 1'b0);
    tick();
    val = 1'b0; en = 4'd0;
    check_bit("bp_second_accepted", busy_w[0], 1'b1);
    drain();

    // Flush in the second RUN cycle.
    issue(4'b0001, FN_OK, IMM_ENC, V_A, C_A, ct_a, 4'b0001);
    en = 4'b0001;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; en = 4'd0;
    void'(exp_q[0].pop_back());
    void'(cyc_q[0].pop_back());
    check_bit("flush_run_busy", busy_w[0], 1'b0);
    check_bit("flush_run_oval", oval_w[0], 1'b0);
    check_bit("flush_run_rdy", rdy_w[0], 1'b1);
    repeat (6) tick();
    issue(4'b0001, FN_OK, IMM_ENC, V_B, C_B, ct_b, 4'b0001);
    drain();

    // Flush while the response is waiting in DONE.
    ordy = 4'b1110;
    issue(4'b0001, FN_OK, IMM_ENC, V_ONE, 64'd0, K_ONE, 4'b0001);
    wait_oval(0);
    en = 4'b0001; flush = 1'b1;
    tick();
    flush = 1'b0; en = 4'd0;
    void'(exp_q[0].pop_front());
    void'(cyc_q[0].pop_front());
    check_bit("flush_done_oval", oval_w[0], 1'b0);
    check_bit("flush_done_busy", busy_w[0], 1'b0);
    ordy = 4'hF;
    repeat (3) tick();
    issue(4'b0001, FN_OK, IMM_DEC, ct_a, C_A, V_A, 4'b0001);
    drain();

    // Flush together with a request: the request is dropped.
    fn = FN_OK; imm = IMM_ENC; in1 = V_A; in2 = C_A; en = 4'b0001; val = 1'b1; flush = 1'b1;
    tick();
    val = 1'b0; flush = 1'b0; en = 4'd0;
    check_bit("flush_accept_busy", busy_w[0], 1'b0);
    repeat (6) tick();

    for (int l = 0; l < 4; l++) check("final_queue_empty", 64'(exp_q[l].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
